// File: rtl/encoder_homing_ctrl.sv
// Encoder homing sequencer: clear counter, search for index, latch offset, settle.
// Latency: index_in rise to LATCH state is 4 cycles; every output is registered.
// Backpressure: none; start is ignored while busy, abort always takes priority.
module encoder_homing_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 200_000_000,
  parameter int unsigned SETTLE_CYCLES  = 1000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic               index_in,
  input  logic signed [31:0] position,
  output logic               core_enable,
  output logic               core_clr_pos,
  output logic               busy,
  output logic               done,
  output logic               homed,
  output logic               fault,
  output logic signed [31:0] home_offset,
  output logic [2:0]         state
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CLEAR  = 3'd1;
  localparam logic [2:0] ST_SEARCH = 3'd2;
  localparam logic [2:0] ST_LATCH  = 3'd3;
  localparam logic [2:0] ST_SETTLE = 3'd4;
  localparam logic [2:0] ST_FAULT  = 3'd5;

  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] SETTLE_LAST  = 32'(SETTLE_CYCLES - 1);

  // index_in is asynchronous: sync_meta absorbs metastability, sync1/sync2
  // form the synchronizer proper, sync3 holds the previous value for the
  // rising-edge detect.
  logic sync_meta;
  logic sync1;
  logic sync2;
  logic sync3;
  logic index_rise;

  logic [31:0] cnt;

  logic [2:0] state_nxt;
  logic       homed_nxt;
  logic       done_nxt;
  logic       capture;
  logic       busy_nxt;
  logic       fault_nxt;
  logic       clr_nxt;
  logic       enable_nxt;

  assign index_rise = sync2 & ~sync3;

  // Index synchronizer and edge-detect pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_meta <= 1'b0;
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      sync3     <= 1'b0;
    end else begin
      sync_meta <= index_in;
      sync1     <= sync_meta;
      sync2     <= sync1;
      sync3     <= sync2;
    end
  end

  // Next-state logic; abort outranks index, which outranks timeout.
  always_comb begin
    state_nxt = state;
    homed_nxt = homed;
    done_nxt  = 1'b0;
    capture   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!abort && start) begin
          state_nxt = ST_CLEAR;
          homed_nxt = 1'b0;
        end
      end
      ST_CLEAR: begin
        if (abort) begin
          state_nxt = ST_IDLE;
          homed_nxt = 1'b0;
        end else begin
          state_nxt = ST_SEARCH;
        end
      end
      ST_SEARCH: begin
        if (abort) begin
          state_nxt = ST_IDLE;
          homed_nxt = 1'b0;
        end else if (index_rise) begin
          state_nxt = ST_LATCH;
          capture   = 1'b1;
        end else if (cnt == TIMEOUT_LAST) begin
          state_nxt = ST_FAULT;
        end
      end
      ST_LATCH: begin
        if (abort) begin
          state_nxt = ST_IDLE;
          homed_nxt = 1'b0;
        end else begin
          state_nxt = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (abort) begin
          state_nxt = ST_IDLE;
          homed_nxt = 1'b0;
        end else if (cnt == SETTLE_LAST) begin
          state_nxt = ST_IDLE;
          homed_nxt = 1'b1;
          done_nxt  = 1'b1;
        end
      end
      ST_FAULT: begin
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (start) begin
          state_nxt = ST_CLEAR;
          homed_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        homed_nxt = 1'b0;
      end
    endcase
  end

  // Output values derived from the state being entered so they can be registered.
  always_comb begin
    busy_nxt   = (state_nxt == ST_CLEAR) || (state_nxt == ST_SEARCH) ||
                 (state_nxt == ST_LATCH) || (state_nxt == ST_SETTLE);
    fault_nxt  = (state_nxt == ST_FAULT);
    clr_nxt    = (state_nxt == ST_CLEAR) || (state_nxt == ST_LATCH);
    enable_nxt = 1'b0;
    if (state_nxt == ST_IDLE) begin
      enable_nxt = homed_nxt;
    end else if ((state_nxt == ST_SEARCH) || (state_nxt == ST_LATCH) ||
                 (state_nxt == ST_SETTLE)) begin
      enable_nxt = 1'b1;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      homed        <= 1'b0;
      done         <= 1'b0;
      busy         <= 1'b0;
      fault        <= 1'b0;
      core_clr_pos <= 1'b0;
      core_enable  <= 1'b0;
      home_offset  <= '0;
    end else begin
      state        <= state_nxt;
      homed        <= homed_nxt;
      done         <= done_nxt;
      busy         <= busy_nxt;
      fault        <= fault_nxt;
      core_clr_pos <= clr_nxt;
      core_enable  <= enable_nxt;
      if (capture) begin
        home_offset <= position;
      end
    end
  end

  // Per-state cycle counter: zero on every state entry, counts only in timed
  // states; both timed states leave at their terminal count so it never wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (state_nxt != state) begin
      cnt <= '0;
    end else if ((state == ST_SEARCH) || (state == ST_SETTLE)) begin
      cnt <= cnt + 32'd1;
    end else begin
      cnt <= '0;
    end
  end

endmodule

// File: tb/tb_encoder_homing_ctrl.sv
// Self-checking bench for encoder_homing_ctrl (TIMEOUT_CYCLES=100, SETTLE_CYCLES=4).
// Expected output snapshots are queued per cycle as stimulus is scheduled.
// A negedge monitor pops and compares them as the DUT reaches each cycle.
module tb_encoder_homing_ctrl;

  logic               clk;
  logic               reset;
  logic               start;
  logic               abort;
  logic               index_in;
  logic signed [31:0] position;
  logic               core_enable;
  logic               core_clr_pos;
  logic               busy;
  logic               done;
  logic               homed;
  logic               fault;
  logic signed [31:0] home_offset;
  logic [2:0]         state;

  encoder_homing_ctrl #(
    .TIMEOUT_CYCLES(100),
    .SETTLE_CYCLES (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .index_in    (index_in),
    .position    (position),
    .core_enable (core_enable),
    .core_clr_pos(core_clr_pos),
    .busy        (busy),
    .done        (done),
    .homed       (homed),
    .fault       (fault),
    .home_offset (home_offset),
    .state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    string       tag;
    logic [63:0] val;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_total = 0;
  int   n_pass = 0;
  int   t;
  int   c;

  logic [63:0] obs;
  assign obs = {23'd0, state, core_enable, core_clr_pos, busy, done, homed, fault, home_offset};

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_total++;
    if (got === want) begin
      n_pass++;
    end else begin
      $display("FAIL %s @cyc %0d: got %h, expected %h", tag, cyc, got, want);
    end
  endtask

  // Packs an expected output snapshot in the same layout as obs.
  function automatic logic [63:0] mk(input logic [2:0] st, input logic en, input logic clr,
                                     input logic bsy, input logic dn, input logic hm,
                                     input logic flt, input logic [31:0] off);
    mk = {23'd0, st, en, clr, bsy, dn, hm, flt, off};
  endfunction

  task automatic expect_at(input int at, input string tag, input logic [63:0] v);
    exp_t e;
    e.cyc = at;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_to(input int target);
    while (cyc < target) tick();
  endtask

  // Scoreboard monitor: compare every entry due at the current cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      if (mon_e.cyc == cyc) check_val(mon_e.tag, obs, mon_e.val);
      else check_val({mon_e.tag, "_missed"}, cyc, mon_e.cyc);
    end
  end

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    index_in = 1'b0;
    position = 0;

    // Reset state
    expect_at(cyc + 1, "reset", mk(3'd0, 0, 0, 0, 0, 0, 0, 0));
    tick();
    reset = 1'b0;
    tick();

    // Full homing sequence, index at +10, position 37
    t = cyc;
    position = 37;
    expect_at(t + 1,  "h_clear",  mk(3'd1, 0, 1, 1, 0, 0, 0, 0));
    expect_at(t + 2,  "h_search", mk(3'd2, 1, 0, 1, 0, 0, 0, 0));
    expect_at(t + 13, "h_prelat", mk(3'd2, 1, 0, 1, 0, 0, 0, 0));
    expect_at(t + 14, "h_latch",  mk(3'd3, 1, 1, 1, 0, 0, 0, 37));
    for (int i = 15; i <= 18; i++) expect_at(t + i, "h_settle", mk(3'd4, 1, 0, 1, 0, 0, 0, 37));
    expect_at(t + 19, "h_done",   mk(3'd0, 1, 0, 0, 1, 1, 0, 37));
    expect_at(t + 20, "h_idle",   mk(3'd0, 1, 0, 0, 0, 1, 0, 37));
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_to(t + 10);
    index_in = 1'b1;
    wait_to(t + 22);
    index_in = 1'b0;
    repeat (4) tick();

    // Index pulse while idle must not move home_offset
    c = cyc;
    position = 99;
    expect_at(c + 9, "idle_index", mk(3'd0, 1, 0, 0, 0, 1, 0, 37));
    index_in = 1'b1;
    repeat (3) tick();
    index_in = 1'b0;
    wait_to(c + 12);

    // start together with abort in IDLE resolves to abort
    c = cyc;
    expect_at(c + 1, "start_abort", mk(3'd0, 1, 0, 0, 0, 1, 0, 37));
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    tick();

    // Timeout with an ignored start during SEARCH
    t = cyc;
    position = 5;
    expect_at(t + 1,   "to_clear",  mk(3'd1, 0, 1, 1, 0, 0, 0, 37));
    expect_at(t + 2,   "to_search", mk(3'd2, 1, 0, 1, 0, 0, 0, 37));
    expect_at(t + 7,   "to_ignst",  mk(3'd2, 1, 0, 1, 0, 0, 0, 37));
    expect_at(t + 101, "to_last",   mk(3'd2, 1, 0, 1, 0, 0, 0, 37));
    expect_at(t + 102, "to_fault",  mk(3'd5, 0, 0, 0, 0, 0, 1, 37));
    expect_at(t + 110, "to_hold",   mk(3'd5, 0, 0, 0, 0, 0, 1, 37));
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_to(t + 5);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_to(t + 112);

    // Restart from FAULT; index_rise lands exactly on counter 99
    t = cyc;
    position = 555;
    expect_at(t + 1,   "sim_clear",  mk(3'd1, 0, 1, 1, 0, 0, 0, 37));
    expect_at(t + 101, "sim_search", mk(3'd2, 1, 0, 1, 0, 0, 0, 37));
    expect_at(t + 102, "sim_latch",  mk(3'd3, 1, 1, 1, 0, 0, 0, 555));
    expect_at(t + 106, "sim_settle", mk(3'd4, 1, 0, 1, 0, 0, 0, 555));
    expect_at(t + 107, "sim_done",   mk(3'd0, 1, 0, 0, 1, 1, 0, 555));
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_to(t + 98);
    index_in = 1'b1;
    wait_to(t + 108);
    index_in = 1'b0;
    repeat (4) tick();

    // Abort in the third SETTLE cycle
    t = cyc;
    position = 1234;
    expect_at(t + 14, "ab_latch",  mk(3'd3, 1, 1, 1, 0, 0, 0, 1234));
    expect_at(t + 17, "ab_settle", mk(3'd4, 1, 0, 1, 0, 0, 0, 1234));
    for (int i = 18; i <= 23; i++) expect_at(t + i, "ab_idle", mk(3'd0, 0, 0, 0, 0, 0, 0, 1234));
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_to(t + 10);
    index_in = 1'b1;
    wait_to(t + 17);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    wait_to(t + 24);
    index_in = 1'b0;
    repeat (4) tick();

    // Abort coinciding with index_rise
    t = cyc;
    position = 777;
    expect_at(t + 13, "abx_search", mk(3'd2, 1, 0, 1, 0, 0, 0, 1234));
    expect_at(t + 14, "abx_idle",   mk(3'd0, 0, 0, 0, 0, 0, 0, 1234));
    expect_at(t + 16, "abx_hold",   mk(3'd0, 0, 0, 0, 0, 0, 0, 1234));
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_to(t + 10);
    index_in = 1'b1;
    wait_to(t + 13);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    wait_to(t + 18);
    index_in = 1'b0;
    repeat (4) tick();

    // Reset at SEARCH counter 50
    t = cyc;
    expect_at(t + 52, "rst_search", mk(3'd2, 1, 0, 1, 0, 0, 0, 1234));
    expect_at(t + 53, "rst_zero",   mk(3'd0, 0, 0, 0, 0, 0, 0, 0));
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_to(t + 52);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();

    // Fresh full sequence after reset
    t = cyc;
    position = 42;
    expect_at(t + 1,  "re_clear", mk(3'd1, 0, 1, 1, 0, 0, 0, 0));
    expect_at(t + 14, "re_latch", mk(3'd3, 1, 1, 1, 0, 0, 0, 42));
    expect_at(t + 19, "re_done",  mk(3'd0, 1, 0, 0, 1, 1, 0, 42));
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_to(t + 10);
    index_in = 1'b1;
    wait_to(t + 22);
    index_in = 1'b0;
    repeat (2) tick();

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 10 && sb.size() > 0; i++) tick();
    check_val("drain", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
